// File: rtl/accel_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : accel_mem_arbiter
// Description : Shares one data-memory port between the CPU load/store path
//               and the accelerator. Accelerator line reads are sequenced as
//               LINE_WORDS back-to-back word reads. CPU and accelerator
//               transactions are arbitrated round-robin. The arbiter also
//               produces the accelerator write-done and read-valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_cpu_req,
    input  logic                         i_cpu_we,
    input  logic [ADDR_W-1:0]            i_cpu_addr,
    input  logic [WORD_W-1:0]            i_cpu_wdata,
    output logic                         o_cpu_gnt,
    output logic                         o_cpu_rvalid,
    output logic [WORD_W-1:0]            o_cpu_rdata,
    input  logic                         i_acc_wr_en,
    input  logic                         i_acc_rd_en,
    input  logic [ADDR_W-1:0]            i_acc_addr,
    input  logic [WORD_W-1:0]            i_acc_wdata,
    output logic                         o_acc_busy,
    output logic                         o_acc_write_done,
    output logic                         o_acc_read_valid,
    output logic [LINE_WORDS*WORD_W-1:0] o_acc_rdata,
    output logic                         o_mem_en,
    output logic                         o_mem_we,
    output logic [ADDR_W-1:0]            o_mem_addr,
    output logic [WORD_W-1:0]            o_mem_wdata,
    input  logic [WORD_W-1:0]            i_mem_rdata
);

    localparam int                  c_BEAT_W    = $clog2(LINE_WORDS);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACC_RD = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [c_BEAT_W-1:0]            r_beat;
    logic                           r_pending;
    logic                           r_busy;
    logic                           r_acc_wr;
    logic [ADDR_W-1:0]              r_acc_addr;
    logic [WORD_W-1:0]              r_acc_wdata;
    logic                           r_last_acc;
    logic                           r_tag_cpu;
    logic                           r_tag_acc;
    logic [c_BEAT_W-1:0]            r_tag_beat;
    logic                           r_wdone;
    logic                           r_rvalid_acc;
    logic [LINE_WORDS*WORD_W-1:0]   r_acc_rdata;

    logic                           w_cpu_win;
    logic                           w_acc_win;
    logic                           w_acc_rd_issue;
    logic [c_BEAT_W-1:0]            w_beat_issue;
    logic                           w_mem_en;
    logic                           w_mem_we;
    logic [ADDR_W-1:0]              w_mem_addr;
    logic [WORD_W-1:0]              w_mem_wdata;
    logic                           w_last_return;

    // The final beat of a line is coming back from memory this cycle.
    assign w_last_return = r_tag_acc && (r_tag_beat == c_LAST_BEAT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration, burst sequencing and memory-port drive.
    always_comb begin
        w_state_nxt    = r_state;
        w_cpu_win      = 1'b0;
        w_acc_win      = 1'b0;
        w_acc_rd_issue = 1'b0;
        w_beat_issue   = '0;
        w_mem_en       = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr     = '0;
        w_mem_wdata    = '0;
        case (r_state)
            S_IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (i_cpu_req && (!r_pending || r_last_acc)) begin
                    w_cpu_win   = 1'b1;
                    w_mem_en    = 1'b1;
                    w_mem_we    = i_cpu_we;
                    w_mem_addr  = i_cpu_addr;
                    w_mem_wdata = i_cpu_wdata;
                end else if (r_pending) begin
                    w_acc_win = 1'b1;
                    w_mem_en  = 1'b1;
                    if (r_acc_wr) begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = r_acc_addr;
                        w_mem_wdata = r_acc_wdata;
                    end else begin
                        w_acc_rd_issue = 1'b1;
                        w_mem_addr     = {r_acc_addr[ADDR_W-1:c_BEAT_W], w_beat_issue};
                        w_state_nxt    = S_ACC_RD;
                    end
                end
            end
            S_ACC_RD: begin
                // Remaining beats own the port; the CPU waits.
                w_acc_rd_issue = 1'b1;
                w_beat_issue   = r_beat;
                w_mem_en       = 1'b1;
                w_mem_addr     = {r_acc_addr[ADDR_W-1:c_BEAT_W], w_beat_issue};
                if (r_beat == c_LAST_BEAT) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, round-robin history, read-return tags and line assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat       <= '0;
            r_pending    <= 1'b0;
            r_busy       <= 1'b0;
            r_acc_wr     <= 1'b0;
            r_acc_addr   <= '0;
            r_acc_wdata  <= '0;
            r_last_acc   <= 1'b1;
            r_tag_cpu    <= 1'b0;
            r_tag_acc    <= 1'b0;
            r_tag_beat   <= '0;
            r_wdone      <= 1'b0;
            r_rvalid_acc <= 1'b0;
            r_acc_rdata  <= '0;
        end else begin
            // Beat index wraps back to zero after the last beat of a line.
            if (w_acc_rd_issue) begin
                r_beat <= w_beat_issue + 1'b1;
            end

            if (!r_busy && (i_acc_wr_en || i_acc_rd_en)) begin
                r_busy      <= 1'b1;
                r_pending   <= 1'b1;
                r_acc_wr    <= i_acc_wr_en;
                r_acc_addr  <= i_acc_addr;
                r_acc_wdata <= i_acc_wdata;
            end else begin
                if (w_acc_win) begin
                    r_pending <= 1'b0;
                end
                if ((w_acc_win && r_acc_wr) || w_last_return) begin
                    r_busy <= 1'b0;
                end
            end

            if (w_cpu_win) begin
                r_last_acc <= 1'b0;
            end else if (w_acc_win) begin
                r_last_acc <= 1'b1;
            end

            r_tag_cpu    <= w_cpu_win && !i_cpu_we;
            r_tag_acc    <= w_acc_rd_issue;
            r_tag_beat   <= w_beat_issue;
            r_wdone      <= w_acc_win && r_acc_wr;
            r_rvalid_acc <= w_last_return;

            for (int i = 0; i < LINE_WORDS; i++) begin
                if (r_tag_acc && (r_tag_beat == c_BEAT_W'(i))) begin
                    r_acc_rdata[WORD_W*i +: WORD_W] <= i_mem_rdata;
                end
            end
        end
    end

    assign o_cpu_gnt        = w_cpu_win;
    assign o_cpu_rvalid     = r_tag_cpu;
    assign o_cpu_rdata      = r_tag_cpu ? i_mem_rdata : '0;
    assign o_acc_busy       = r_busy;
    assign o_acc_write_done = r_wdone;
    assign o_acc_read_valid = r_rvalid_acc;
    assign o_acc_rdata      = r_acc_rdata;
    assign o_mem_en         = w_mem_en;
    assign o_mem_we         = w_mem_we;
    assign o_mem_addr       = w_mem_addr;
    assign o_mem_wdata      = w_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_accel_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_accel_mem_arbiter
// Description : Self-checking bench for accel_mem_arbiter with a memory model
//               and a transaction-level reference of the sharing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int WORD_W = 32;
    localparam int LW     = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cpu_req = 1'b0;
    logic                   cpu_we = 1'b0;
    logic [ADDR_W-1:0]      cpu_addr = '0;
    logic [WORD_W-1:0]      cpu_wdata = '0;
    logic                   acc_wr_en = 1'b0;
    logic                   acc_rd_en = 1'b0;
    logic [ADDR_W-1:0]      acc_addr = '0;
    logic [WORD_W-1:0]      acc_wdata = '0;
    logic [WORD_W-1:0]      mem_rdata = '0;

    logic                   w_cpu_gnt, w_cpu_rvalid, w_acc_busy, w_acc_write_done;
    logic                   w_acc_read_valid, w_mem_en, w_mem_we;
    logic [WORD_W-1:0]      w_cpu_rdata, w_mem_wdata;
    logic [ADDR_W-1:0]      w_mem_addr;
    logic [LW*WORD_W-1:0]   w_acc_rdata;

    accel_mem_arbiter #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(LW)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .i_cpu_req        (cpu_req),
        .i_cpu_we         (cpu_we),
        .i_cpu_addr       (cpu_addr),
        .i_cpu_wdata      (cpu_wdata),
        .o_cpu_gnt        (w_cpu_gnt),
        .o_cpu_rvalid     (w_cpu_rvalid),
        .o_cpu_rdata      (w_cpu_rdata),
        .i_acc_wr_en      (acc_wr_en),
        .i_acc_rd_en      (acc_rd_en),
        .i_acc_addr       (acc_addr),
        .i_acc_wdata      (acc_wdata),
        .o_acc_busy       (w_acc_busy),
        .o_acc_write_done (w_acc_write_done),
        .o_acc_read_valid (w_acc_read_valid),
        .o_acc_rdata      (w_acc_rdata),
        .o_mem_en         (w_mem_en),
        .o_mem_we         (w_mem_we),
        .o_mem_addr       (w_mem_addr),
        .o_mem_wdata      (w_mem_wdata),
        .i_mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: one access per cycle, read data the cycle after issue.
    logic [WORD_W-1:0] mem  [0:65535];
    logic [WORD_W-1:0] gold [0:65535];
    always @(posedge clk) begin
        if (w_mem_en && w_mem_we) mem[w_mem_addr] = w_mem_wdata;
        if (w_mem_en && !w_mem_we) mem_rdata <= mem[w_mem_addr];
        else                       mem_rdata <= $urandom;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } cpu_op_t;
    cpu_op_t cpu_q[$];

    // Reference state, expressed as transactions rather than hardware state.
    bit                m_acc_wait, m_acc_out, m_acc_wr, m_last_acc, m_wdone_due, m_crv_due;
    bit                m_cpu_granted, chk_zero;
    logic [ADDR_W-1:0] m_acc_addr;
    logic [WORD_W-1:0] m_acc_wdata, m_crv_data, last_crv_data;
    int                m_burst_left, m_rv_cnt, cyc;
    logic [WORD_W-1:0] m_line [LW];
    int                gnt_log[$], wdone_log[$], arv_log[$], crv_log[$];
    logic [ADDR_W-1:0] addr_log[$], wr_log[$];

    task automatic model_reset();
        m_acc_wait = 0; m_acc_out = 0; m_acc_wr = 0; m_last_acc = 1;
        m_wdone_due = 0; m_crv_due = 0; m_burst_left = 0; m_rv_cnt = 0;
    endtask

    task automatic clear_logs();
        gnt_log.delete(); wdone_log.delete(); arv_log.delete(); crv_log.delete();
        addr_log.delete(); wr_log.delete();
    endtask

    task automatic cpu_push(input logic we, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        cpu_op_t op;
        op.we = we; op.addr = a; op.wdata = d;
        cpu_q.push_back(op);
    endtask

    // Predict this cycle's outputs, compare, then advance the reference past the edge.
    task automatic check_cycle();
        bit e_en, e_we, e_gnt, e_wdone, e_arv, e_crv, e_busy, start_burst, last_beat, acc_wr_grant;
        logic [ADDR_W-1:0] e_addr;
        logic [WORD_W-1:0] e_wd;
        e_en = 0; e_we = 0; e_gnt = 0; start_burst = 0; last_beat = 0; acc_wr_grant = 0;
        e_addr = '0; e_wd = '0;
        m_cpu_granted = 0;
        if (rst) begin
            model_reset();
            return;
        end
        e_wdone = m_wdone_due;
        e_crv   = m_crv_due;
        e_arv   = (m_rv_cnt == 1);
        e_busy  = m_acc_out && !(e_wdone || e_arv);
        if (m_burst_left > 0) begin
            e_en = 1; e_addr = m_acc_addr & ~16'(LW - 1);
            e_addr = e_addr + 16'(LW - m_burst_left);
            last_beat = (m_burst_left == 1);
        end else if (cpu_req && (!m_acc_wait || m_last_acc)) begin
            e_gnt = 1; e_en = 1; e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
        end else if (m_acc_wait) begin
            e_en = 1;
            if (m_acc_wr) begin
                e_we = 1; e_addr = m_acc_addr; e_wd = m_acc_wdata; acc_wr_grant = 1;
            end else begin
                e_addr = m_acc_addr & ~16'(LW - 1); start_burst = 1;
            end
        end

        check("cpu_gnt", w_cpu_gnt, e_gnt);
        check("mem_en", w_mem_en, e_en);
        if (e_en) begin
            check("mem_we", w_mem_we, e_we);
            check("mem_addr", w_mem_addr, e_addr);
        end
        if (e_we) check("mem_wdata", w_mem_wdata, e_wd);
        check("cpu_rvalid", w_cpu_rvalid, e_crv);
        if (e_crv) check("cpu_rdata", w_cpu_rdata, m_crv_data);
        check("acc_write_done", w_acc_write_done, e_wdone);
        check("acc_read_valid", w_acc_read_valid, e_arv);
        check("acc_busy", w_acc_busy, e_busy);
        if (e_arv) begin
            for (int i = 0; i < LW; i++) check("acc_rdata_word", w_acc_rdata[WORD_W*i +: WORD_W], m_line[i]);
        end
        if (chk_zero) begin
            chk_zero = 0;
            check("rst_cpu_rdata", w_cpu_rdata, 0);
            check("rst_mem_we", w_mem_we, 0);
            check("rst_mem_addr", w_mem_addr, 0);
            check("rst_mem_wdata", w_mem_wdata, 0);
            for (int i = 0; i < LW; i++) check("rst_acc_rdata", w_acc_rdata[WORD_W*i +: WORD_W], 0);
        end

        if (w_cpu_gnt) gnt_log.push_back(cyc);
        if (w_acc_write_done) wdone_log.push_back(cyc);
        if (w_acc_read_valid) arv_log.push_back(cyc);
        if (w_cpu_rvalid) begin crv_log.push_back(cyc); last_crv_data = w_cpu_rdata; end
        if (w_mem_en) addr_log.push_back(w_mem_addr);
        if (w_mem_en && w_mem_we) wr_log.push_back(w_mem_addr);

        m_wdone_due = acc_wr_grant;
        m_crv_due   = e_gnt && !e_we;
        if (e_gnt && !e_we) m_crv_data = gold[e_addr];
        if ((e_gnt || acc_wr_grant) && e_we) gold[e_addr] = e_wd;
        if (e_gnt) begin m_last_acc = 0; m_cpu_granted = 1; end
        if (acc_wr_grant || start_burst) begin m_last_acc = 1; m_acc_wait = 0; end
        if (m_rv_cnt > 0) m_rv_cnt--;
        if (start_burst) begin
            for (int i = 0; i < LW; i++) m_line[i] = gold[16'(e_addr + i)];
            m_burst_left = LW - 1;
        end else if (m_burst_left > 0) begin
            m_burst_left--;
            if (last_beat) m_rv_cnt = 2;
        end
        if (e_wdone || e_arv) m_acc_out = 0;
        if (!e_busy && (acc_wr_en || acc_rd_en)) begin
            m_acc_out = 1; m_acc_wait = 1; m_acc_wr = acc_wr_en;
            m_acc_addr = acc_addr; m_acc_wdata = acc_wdata;
        end
    endtask

    // Check the current cycle, then move to the next one and refresh CPU/acc drive.
    task automatic cycle_end();
        cpu_op_t op;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
        acc_wr_en = 0;
        acc_rd_en = 0;
        if (m_cpu_granted) cpu_req = 0;
        if (!cpu_req && cpu_q.size() > 0) begin
            op = cpu_q.pop_front();
            cpu_req = 1; cpu_we = op.we; cpu_addr = op.addr; cpu_wdata = op.wdata;
        end
    endtask

    task automatic do_reset();
        cpu_q.delete();
        cpu_req = 0; acc_wr_en = 0; acc_rd_en = 0; rst = 1;
        cycle_end();
        rst = 0;
    endtask

    int t0;

    initial begin
        for (int k = 0; k < 65536; k++) begin
            mem[k]  = 32'h1000 + k;
            gold[k] = 32'h1000 + k;
        end
        model_reset();
        cyc = 0; chk_zero = 0; last_crv_data = '0;
        @(posedge clk); #1;
        do_reset();
        chk_zero = 1;

        // CPU write then read back, uncontended.
        clear_logs(); t0 = cyc;
        cpu_push(1'b1, 16'h0010, 32'hDEADBEEF);
        cpu_push(1'b0, 16'h0010, 32'h0);
        repeat (5) cycle_end();
        check("t1_gnt_count", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("t1_wr_gnt_cycle", gnt_log[0] - t0, 1);
            check("t1_rd_gnt_cycle", gnt_log[1] - t0, 2);
        end
        check("t1_rvalid_cycle", (crv_log.size() == 1) ? crv_log[0] - t0 : -1, 3);
        check("t1_rdata", last_crv_data, 32'hDEADBEEF);

        // Accelerator line read at an unaligned address.
        clear_logs(); t0 = cyc;
        acc_rd_en = 1; acc_addr = 16'h0123;
        repeat (21) cycle_end();
        check("t2_beats", addr_log.size(), 16);
        for (int i = 0; i < LW; i++)
            if (i < addr_log.size()) check("t2_beat_addr", addr_log[i], 16'h0120 + i);
        check("t2_valid_cycle", (arv_log.size() == 1) ? arv_log[0] - t0 : -1, 18);
        for (int i = 0; i < LW; i++) check("t2_word", w_acc_rdata[WORD_W*i +: WORD_W], 32'h1120 + i);

        // CPU and accelerator write tie twice in a row.
        clear_logs(); t0 = cyc;
        acc_wr_en = 1; acc_addr = 16'h0200; acc_wdata = 32'hA5A50001;
        cpu_push(1'b1, 16'h0300, 32'h11111111);
        cpu_push(1'b1, 16'h0301, 32'h22222222);
        repeat (6) cycle_end();
        check("t3_gnt_count", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("t3_cpu_first", gnt_log[0] - t0, 1);
            check("t3_cpu_third", gnt_log[1] - t0, 3);
        end
        check("t3_order", (addr_log.size() == 3) ? addr_log[1] : 16'hFFFF, 16'h0200);
        check("t3_wdone_count", wdone_log.size(), 1);

        // CPU read arriving while the accelerator burst runs.
        clear_logs(); t0 = cyc;
        acc_rd_en = 1; acc_addr = 16'h0040;
        cpu_push(1'b0, 16'h0010, 32'h0);
        repeat (21) cycle_end();
        check("t4_gnt_cycle", (gnt_log.size() == 1) ? gnt_log[0] - t0 : -1, 17);
        check("t4_rvalid_cycle", (crv_log.size() == 1) ? crv_log[0] - t0 : -1, 18);
        check("t4_valid_cycle", (arv_log.size() == 1) ? arv_log[0] - t0 : -1, 18);
        check("t4_cpu_data", last_crv_data, 32'hDEADBEEF);
        for (int i = 0; i < LW; i++) check("t4_word", w_acc_rdata[WORD_W*i +: WORD_W], 32'h1040 + i);

        // Both accelerator enables together: write wins, read dropped.
        clear_logs(); t0 = cyc;
        acc_wr_en = 1; acc_rd_en = 1; acc_addr = 16'h0500; acc_wdata = 32'hCAFEF00D;
        repeat (22) cycle_end();
        check("t5_writes", wr_log.size(), 1);
        check("t5_wdone_count", wdone_log.size(), 1);
        check("t5_no_read_valid", arv_log.size(), 0);
        cpu_push(1'b0, 16'h0500, 32'h0);
        repeat (4) cycle_end();
        check("t5_written_data", last_crv_data, 32'hCAFEF00D);

        // Reset in the middle of a burst (beat 8).
        t0 = cyc;
        acc_rd_en = 1; acc_addr = 16'h0080;
        repeat (9) cycle_end();
        rst = 1;
        cycle_end();
        rst = 0;
        chk_zero = 1;
        clear_logs();
        repeat (20) cycle_end();
        check("t6_no_read_valid", arv_log.size(), 0);
        check("t6_no_mem_traffic", addr_log.size(), 0);
        check("t6_busy", w_acc_busy, 0);

        // Randomized traffic against the reference.
        for (int n = 0; n < 3000; n++) begin
            if (cpu_q.size() == 0 && !cpu_req && $urandom_range(0, 2) == 0)
                cpu_push(1'($urandom_range(0, 1)), 16'($urandom_range(0, 1023)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                acc_wr_en = 1'($urandom_range(0, 1));
                acc_rd_en = 1'($urandom_range(0, 1));
                acc_addr  = 16'($urandom_range(0, 1023));
                acc_wdata = $urandom;
            end
            cycle_end();
        end
        cpu_q.delete();
        repeat (40) cycle_end();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
